// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   DEF_WIDTH / DEF_DIGIT : default operand width and bits processed per cycle
//   state_t               : control FSM encoding
//   idx_bits()            : digit-index width, clog2(N) with a floor of 1
package serial_adder_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// DIGIT-bit ripple-carry adder slice.
//   a, b  : slice operands
//   cin   : carry into bit 0
//   s     : slice sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (needed for signed overflow)
module adder_slice
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder_param.sv
// Digit-serial adder/subtractor. Adds DIGIT bits per cycle, LSB first,
// over N = WIDTH/DIGIT cycles using one shared adder_slice.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   A, B, carry_in, sub : operands; sub=1 computes A-B and ignores carry_in
//   out_valid/out_ready : result handshake (valid only in DONE)
//   sum, carry, overflow: result, MSB carry-out (1 = no borrow on sub),
//                         signed overflow
module serial_adder_param
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int IW = idx_bits(N);
  localparam logic [IW-1:0]    LAST  = IW'(N - 1);
  localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

  if (WIDTH % DIGIT != 0) begin : g_bad_cfg
    $error("WIDTH must be a multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;       // shifted right one digit per RUN cycle
  logic             c_q;            // running carry between digits
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] sum_q, sum_nxt;
  logic             carry_q, ovf_q;

  logic [DIGIT-1:0] sl_s;
  logic             sl_cout, sl_cmsb;
  int               shamt;

  logic accept, retire, last_dig;

  assign accept   = (state_q == ST_IDLE) && in_valid;
  assign retire   = (state_q == ST_DONE) && out_ready;
  assign last_dig = (idx_q == LAST);

  // Operands are consumed from the bottom, so the slice always sees bit 0.
  adder_slice #(.DIGIT(DIGIT)) u_slice (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (c_q),
    .s     (sl_s),
    .cout  (sl_cout),
    .c_msb (sl_cmsb)
  );

  // Merge the freshly computed digit into its position in the result.
  assign shamt = int'(idx_q) * DIGIT;
  always_comb begin
    sum_nxt = (sum_q & ~(DMASK << shamt)) | (WIDTH'(sl_s) << shamt);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_RUN;
      ST_RUN:  if (last_dig) state_d = ST_DONE;
      ST_DONE: if (retire)   state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
  end

  assign sum      = sum_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1.
      a_q   <= A;
      b_q   <= B ^ {WIDTH{sub}};
      c_q   <= sub | carry_in;
      idx_q <= '0;
    end else if (state_q == ST_RUN) begin
      sum_q <= sum_nxt;
      c_q   <= sl_cout;
      idx_q <= idx_q + 1'b1;
      a_q   <= a_q >> DIGIT;
      b_q   <= b_q >> DIGIT;
      if (last_dig) begin
        carry_q <= sl_cout;
        ovf_q   <= sl_cmsb ^ sl_cout;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_param.sv
// Directed + random bench for serial_adder_param at DIGIT = 4, 1 and 16
// (all WIDTH = 16). Instance k: 0 -> DIGIT 4, 1 -> DIGIT 1, 2 -> DIGIT 16.
module tb_serial_adder_param;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [2:0]          iv, ir, ov, ordy, cin, sb, cy, of;
  logic [2:0][15:0]    av, bv, sv;

  int checks = 0;
  int errors = 0;
  int nlat [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  serial_adder_param #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .A(av[0]), .B(bv[0]), .carry_in(cin[0]), .sub(sb[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .sum(sv[0]), .carry(cy[0]), .overflow(of[0]));

  serial_adder_param #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .A(av[1]), .B(bv[1]), .carry_in(cin[1]), .sub(sb[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .sum(sv[1]), .carry(cy[1]), .overflow(of[1]));

  serial_adder_param #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .A(av[2]), .B(bv[2]), .carry_in(cin[2]), .sub(sb[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .sum(sv[2]), .carry(cy[2]), .overflow(of[2]));

  typedef struct {
    logic [15:0] a, b;
    logic        ci, su;
    logic [15:0] e_sum;
    logic        e_c, e_v;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  // Present operands at a negedge; accepted on the following posedge.
  task automatic issue(input int k, input logic [15:0] a, b, input logic ci, su);
    @(negedge clk);
    iv[k] = 1'b1; av[k] = a; bv[k] = b; cin[k] = ci; sb[k] = su;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0;
  endtask

  // Count edges from the accepting edge until out_valid; bounded.
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!ov[k] && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take(input int k);
    ordy[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[k] = 1'b0;
  endtask

  initial begin
    int          lat;
    logic [15:0] bb, es;
    logic [16:0] full;
    logic        ev, ci, su;
    logic [15:0] ra, rb;

    iv = '0; ordy = '0; cin = '0; sb = '0; av = '0; bv = '0;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[7] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
    tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[9] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};

    // Reset state
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(ir[k]), 32'd1);
      chk("rst_out_valid", 32'(ov[k]), 32'd0);
      chk("rst_sum", 32'(sv[k]), 32'd0);
      chk("rst_carry_ovf", 32'({cy[k], of[k]}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table on every digit width
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        issue(k, tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].su);
        chk("busy_in_ready", 32'(ir[k]), (nlat[k] == 1) ? 32'd0 : 32'd0);
        wait_done(k, lat);
        chk("latency", 32'(lat), 32'(nlat[k]));
        chk("tbl_sum", 32'(sv[k]), 32'(tbl[i].e_sum));
        chk("tbl_carry", 32'(cy[k]), 32'(tbl[i].e_c));
        chk("tbl_ovf", 32'(of[k]), 32'(tbl[i].e_v));
        take(k);
        chk("idle_after_take", 32'({ir[k], ov[k]}), 32'b10);
      end
    end

    // Backpressure: result holds, new operands wait until IDLE
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(0, lat);
    chk("bp_latency", 32'(lat), 32'd4);
    iv[0] = 1'b1; av[0] = 16'h1111; bv[0] = 16'h2222; cin[0] = 1'b0; sb[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("bp_hold", 32'({ov[0], ir[0], cy[0], of[0], sv[0]}), {16'h0, 4'b1001, 16'h8000});
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy[0] = 1'b0;
    chk("bp_idle_ready", 32'({ir[0], ov[0]}), 32'b10);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    chk("bp_accepted", 32'(ir[0]), 32'd0);
    wait_done(0, lat);
    chk("bp_new_latency", 32'(lat), 32'd4);
    chk("bp_new_sum", 32'({cy[0], of[0], sv[0]}), {16'h0, 2'b00, 16'h3333});
    take(0);

    // Reset in the second RUN cycle abandons the operation
    issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'({ov[0], cy[0], of[0], sv[0]}), 32'd0);
    chk("mid_rst_in_ready", 32'(ir[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    iv[0] = 1'b1; av[0] = 16'h0003; bv[0] = 16'h0004; cin[0] = 1'b1; sb[0] = 1'b0;
    #1;
    chk("post_rst_ready", 32'(ir[0]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    chk("first_edge_accept", 32'({ir[0], ov[0]}), 32'd0);
    wait_done(0, lat);
    chk("post_rst_latency", 32'(lat), 32'd4);
    chk("post_rst_sum", 32'(sv[0]), 32'h0008);
    take(0);
    // Reset with no operation in flight must not produce a stray result
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("no_stray_valid", 32'(ov[0]), 32'd0);
    end

    // Random regression against an arithmetic model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        ci = 1'($urandom);
        su = 1'($urandom);
        bb = su ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + 17'(su ? 1'b1 : ci);
        es = full[15:0];
        ev = (ra[15] == bb[15]) && (es[15] != ra[15]);
        issue(k, ra, rb, ci, su);
        wait_done(k, lat);
        chk("rnd_latency", 32'(lat), 32'(nlat[k]));
        chk("rnd_result", 32'({of[k], cy[k], sv[k]}), 32'({ev, full}));
        take(k);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
